pc_ghr_hash: RTL and testbench
==============================

// Module: pc_ghr_hash
// PURPOSE
//  Parametrised branch-predictor index generator: folds a PC into K_WIDTH bits and, in
//  gshare mode, XORs it with an incrementally folded global history register (GHR).
//  Keeps a speculative GHR (fetch side) and a committed GHR (retire side); flush restores
//  spec from committed. Sits between fetch PC and the PHT/BTB index ports.
// PARAMETERS
//  ADDR_WIDTH  30  PC bits supplied (PC[31:2]); must be >= K_WIDTH
//  K_WIDTH     12  index width; >= 2
//  HIST_LEN    32  GHR length in branches; >= K_WIDTH
//  MODE        1   0 = PC fold only (history ignored in idx); 1 = gshare (PC fold ^ history fold)
// PORTS
//  clk         in   1           clock, all state on rising edge
//  rst         in   1           synchronous, active-high reset
//  req_valid   in   1           index request this cycle
//  req_pc      in   ADDR_WIDTH  PC to hash
//  idx_valid   out  1           req_valid delayed one cycle
//  idx         out  K_WIDTH     hashed index for the previous cycle's request
//  spec_valid  in   1           speculative branch prediction made this cycle
//  spec_taken  in   1           predicted direction shifted into spec GHR
//  cmt_valid   in   1           branch retired this cycle
//  cmt_taken   in   1           actual direction shifted into committed GHR
//  flush       in   1           mispredict/exception: restore spec state from committed
//  ghr         out  HIST_LEN    current speculative GHR (bit 0 = youngest)
// BEHAVIOUR
//  - Reset: spec/committed GHR and folds = 0; idx = 0; idx_valid = 0. rst overrides all inputs.
//  - PC fold: pcf = XOR of chunks req_pc[i*K_WIDTH +: K_WIDTH], last chunk zero-padded.
//  - Fold invariant (both copies, every cycle): fold[j] = XOR of ghr[i] over all i with
//    i % K_WIDTH == j. Never recomputed from ghr; maintained incrementally.
//  - Shift by bit b (o = ghr[HIST_LEN-1]): ghr' = {ghr[HIST_LEN-2:0], b};
//    fold' = rotl1(fold) ^ b (at bit 0) ^ (o << (HIST_LEN % K_WIDTH)).
//  - Spec update priority: flush > spec_valid. flush: spec <= committed value AFTER this
//    cycle's commit (cmt_valid same cycle is included); spec_valid that cycle is dropped.
//  - Committed copy shifts on cmt_valid regardless of flush/spec_valid.
//  - idx: registered, latency 1. idx <= pcf ^ (MODE ? spec_fold : 0), using spec_fold as
//    registered at the request edge (before that cycle's spec update). idx holds when
//    req_valid = 0; idx_valid = registered req_valid.
//  - ghr output is the registered spec GHR (no combinational path from inputs).
//  - No handshake back-pressure: every request is accepted; one result per request.
// TESTING
//  1. rst 2 cycles then req_valid=1, req_pc=30'h0000_3005, MODE=1 -> next cycle idx_valid=1, idx=12'h006.
//  2. 32 cycles spec_valid=1, spec_taken=1 -> ghr=32'hFFFF_FFFF, spec fold=12'h0FF; then req_pc=0 -> idx=12'h0FF.
//  3. spec diverged (10 taken), committed=0; flush=1 with spec_valid=1 -> next cycle ghr=0, idx of pc 0 = 0.
//  4. committed=0, flush=1 and cmt_valid=1, cmt_taken=1 same cycle -> ghr=32'h1, spec fold=12'h001.
//  5. req_valid=1 with rst=1 mid-stream -> next cycle idx_valid=0, idx=0, ghr=0.
//  6. 10k random cycles of all inputs -> scoreboard: fold invariant holds for both copies; idx matches model; MODE=0 idx = pcf.

Source files
------------

// File: rtl/pc_ghr_hash.sv
// Branch-predictor index generator: folded PC, optionally XORed with an incrementally
// folded global history. Keeps speculative and committed history copies.
module pc_ghr_hash #(
   parameter int ADDR_WIDTH = 30,
   parameter int K_WIDTH    = 12,
   parameter int HIST_LEN   = 32,
   parameter int MODE       = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic [ADDR_WIDTH-1:0] req_pc,
   output logic                  idx_valid,
   output logic [K_WIDTH-1:0]    idx,
   input  logic                  spec_valid,
   input  logic                  spec_taken,
   input  logic                  cmt_valid,
   input  logic                  cmt_taken,
   input  logic                  flush,
   output logic [HIST_LEN-1:0]   ghr
);

   localparam int NCHUNK = (ADDR_WIDTH + K_WIDTH - 1) / K_WIDTH;
   localparam int PADW   = NCHUNK * K_WIDTH;
   localparam int OUT_SH = HIST_LEN % K_WIDTH;

   logic [HIST_LEN-1:0] spec_ghr, cmt_ghr, cmt_ghr_n;
   logic [K_WIDTH-1:0]  spec_fold, cmt_fold, cmt_fold_n, spec_fold_sh;
   logic [PADW-1:0]     pc_pad;
   logic [K_WIDTH-1:0]  pcf;

   // The bit leaving the history sits at fold position OUT_SH after rotation; cancel it there.
   function automatic logic [K_WIDTH-1:0] shift_fold(input logic [K_WIDTH-1:0] f,
                                                     input logic b, input logic o);
      logic [K_WIDTH-1:0] b_vec, o_vec;
      b_vec = '0;
      b_vec[0] = b;
      o_vec = '0;
      o_vec[OUT_SH] = o;
      return {f[K_WIDTH-2:0], f[K_WIDTH-1]} ^ b_vec ^ o_vec;
   endfunction

   always_comb begin
      pc_pad = '0;
      pc_pad[ADDR_WIDTH-1:0] = req_pc;
      pcf = '0;
      for (int c = 0; c < NCHUNK; c++) begin
         pcf = pcf ^ pc_pad[c*K_WIDTH +: K_WIDTH];
      end
   end

   always_comb begin
      cmt_ghr_n  = cmt_ghr;
      cmt_fold_n = cmt_fold;
      if (cmt_valid) begin
         cmt_ghr_n  = {cmt_ghr[HIST_LEN-2:0], cmt_taken};
         cmt_fold_n = shift_fold(cmt_fold, cmt_taken, cmt_ghr[HIST_LEN-1]);
      end
   end

   assign spec_fold_sh = shift_fold(spec_fold, spec_taken, spec_ghr[HIST_LEN-1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         spec_ghr  <= '0;
         spec_fold <= '0;
         cmt_ghr   <= '0;
         cmt_fold  <= '0;
         idx       <= '0;
         idx_valid <= 1'b0;
      end else begin
         cmt_ghr  <= cmt_ghr_n;
         cmt_fold <= cmt_fold_n;
         // Flush restores from the committed copy including this cycle's retirement.
         if (flush) begin
            spec_ghr  <= cmt_ghr_n;
            spec_fold <= cmt_fold_n;
         end else if (spec_valid) begin
            spec_ghr  <= {spec_ghr[HIST_LEN-2:0], spec_taken};
            spec_fold <= spec_fold_sh;
         end
         idx_valid <= req_valid;
         if (req_valid) begin
            idx <= pcf ^ ((MODE != 0) ? spec_fold : '0);
         end
      end
   end

   assign ghr = spec_ghr;

endmodule

// File: tb/tb_pc_ghr_hash.sv
// Directed and randomised checks of pc_ghr_hash in gshare and PC-only modes, against a
// reference model that folds history directly from the GHR bits.
module tb_pc_ghr_hash;
   localparam int AW = 30;
   localparam int K  = 12;
   localparam int H  = 32;

   logic          clk = 1'b0;
   logic          rst, req_valid, spec_valid, spec_taken, cmt_valid, cmt_taken, flush;
   logic [AW-1:0] req_pc;
   logic          iv1, iv0;
   logic [K-1:0]  idx1, idx0;
   logic [H-1:0]  ghr1, ghr0;

   int n_vec = 0;
   int n_err = 0;

   logic [H-1:0] m_spec, m_cmt;
   logic [K-1:0] m_idx1, m_idx0;
   logic         m_iv;

   always #5 clk = ~clk;

   pc_ghr_hash #(.ADDR_WIDTH(AW), .K_WIDTH(K), .HIST_LEN(H), .MODE(1)) dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_pc(req_pc),
      .idx_valid(iv1), .idx(idx1), .spec_valid(spec_valid), .spec_taken(spec_taken),
      .cmt_valid(cmt_valid), .cmt_taken(cmt_taken), .flush(flush), .ghr(ghr1));

   pc_ghr_hash #(.ADDR_WIDTH(AW), .K_WIDTH(K), .HIST_LEN(H), .MODE(0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_pc(req_pc),
      .idx_valid(iv0), .idx(idx0), .spec_valid(spec_valid), .spec_taken(spec_taken),
      .cmt_valid(cmt_valid), .cmt_taken(cmt_taken), .flush(flush), .ghr(ghr0));

   function automatic logic [K-1:0] m_pcf(input logic [AW-1:0] pc);
      logic [K-1:0] r;
      r = '0;
      for (int b = 0; b < AW; b++) r[b % K] = r[b % K] ^ pc[b];
      return r;
   endfunction

   function automatic logic [K-1:0] m_fold(input logic [H-1:0] g);
      logic [K-1:0] r;
      r = '0;
      for (int i = 0; i < H; i++) r[i % K] = r[i % K] ^ g[i];
      return r;
   endfunction

   task automatic idle();
      rst = 0; req_valid = 0; req_pc = '0; spec_valid = 0; spec_taken = 0;
      cmt_valid = 0; cmt_taken = 0; flush = 0;
   endtask

   // One clock: the model computes its next state from the inputs held across the edge.
   task automatic cycle();
      logic [H-1:0] c_n, s_n;
      logic [K-1:0] i1_n, i0_n;
      logic         v_n;
      if (rst) begin
         c_n = '0; s_n = '0; i1_n = '0; i0_n = '0; v_n = 0;
      end else begin
         c_n = cmt_valid ? {m_cmt[H-2:0], cmt_taken} : m_cmt;
         s_n = flush ? c_n : (spec_valid ? {m_spec[H-2:0], spec_taken} : m_spec);
         v_n = req_valid;
         i1_n = req_valid ? (m_pcf(req_pc) ^ m_fold(m_spec)) : m_idx1;
         i0_n = req_valid ? m_pcf(req_pc) : m_idx0;
      end
      @(posedge clk);
      #1;
      m_cmt = c_n; m_spec = s_n; m_idx1 = i1_n; m_idx0 = i0_n; m_iv = v_n;
   endtask

   task automatic test_reset();
      idle(); rst = 1; cycle(); cycle(); rst = 0;
      n_vec++; if (iv1 !== 1'b0) begin n_err++; $display("FAIL reset_idx_valid got %0b want 0", iv1); end
      n_vec++; if (idx1 !== 12'h000) begin n_err++; $display("FAIL reset_idx got %h want 000", idx1); end
      n_vec++; if (ghr1 !== 32'h0) begin n_err++; $display("FAIL reset_ghr got %h want 0", ghr1); end
   endtask

   task automatic test_pc_fold();
      idle(); req_valid = 1; req_pc = 30'h0000_3005; cycle();
      n_vec++; if (iv1 !== 1'b1) begin n_err++; $display("FAIL pcfold_valid got %0b want 1", iv1); end
      n_vec++; if (idx1 !== 12'h006) begin n_err++; $display("FAIL pcfold_idx got %h want 006", idx1); end
      req_pc = 30'h3FFF_FFFF; cycle();
      n_vec++; if (idx1 !== 12'h03F) begin n_err++; $display("FAIL pcfold_ones got %h want 03F", idx1); end
      n_vec++; if (idx0 !== 12'h03F) begin n_err++; $display("FAIL pcfold_mode0 got %h want 03F", idx0); end
      idle(); cycle();
      n_vec++; if (iv1 !== 1'b0 || idx1 !== 12'h03F) begin
         n_err++; $display("FAIL idx_hold got v=%0b idx=%h want v=0 idx=03F", iv1, idx1); end
   endtask

   task automatic test_spec_fill();
      idle(); spec_valid = 1; spec_taken = 1;
      for (int i = 0; i < 32; i++) cycle();
      n_vec++; if (ghr1 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL fill_ghr got %h want FFFFFFFF", ghr1); end
      n_vec++; if (dut1.spec_fold !== 12'h0FF) begin n_err++; $display("FAIL fill_fold got %h want 0FF", dut1.spec_fold); end
      // One more taken shift drops a one off the top: fold must stay 0FF.
      cycle();
      n_vec++; if (dut1.spec_fold !== 12'h0FF) begin n_err++; $display("FAIL fill_wrap got %h want 0FF", dut1.spec_fold); end
      idle(); req_valid = 1; req_pc = '0; cycle();
      n_vec++; if (idx1 !== 12'h0FF) begin n_err++; $display("FAIL fill_idx got %h want 0FF", idx1); end
      n_vec++; if (idx0 !== 12'h000) begin n_err++; $display("FAIL fill_idx_mode0 got %h want 000", idx0); end
      n_vec++; if (dut1.cmt_fold !== 12'h000) begin n_err++; $display("FAIL fill_cmt got %h want 000", dut1.cmt_fold); end
   endtask

   task automatic test_flush();
      idle(); rst = 1; cycle(); rst = 0;
      spec_valid = 1; spec_taken = 1;
      for (int i = 0; i < 10; i++) cycle();
      n_vec++; if (ghr1 !== 32'h0000_03FF) begin n_err++; $display("FAIL flush_pre got %h want 000003FF", ghr1); end
      flush = 1; cycle(); idle();
      n_vec++; if (ghr1 !== 32'h0) begin n_err++; $display("FAIL flush_ghr got %h want 0", ghr1); end
      req_valid = 1; req_pc = '0; cycle();
      n_vec++; if (idx1 !== 12'h000) begin n_err++; $display("FAIL flush_idx got %h want 000", idx1); end
   endtask

   task automatic test_flush_commit();
      idle(); spec_valid = 1; spec_taken = 1;
      for (int i = 0; i < 5; i++) cycle();
      idle(); flush = 1; cmt_valid = 1; cmt_taken = 1; spec_valid = 1; cycle(); idle();
      n_vec++; if (ghr1 !== 32'h1) begin n_err++; $display("FAIL flushcmt_ghr got %h want 1", ghr1); end
      n_vec++; if (dut1.spec_fold !== 12'h001) begin n_err++; $display("FAIL flushcmt_fold got %h want 001", dut1.spec_fold); end
      n_vec++; if (dut1.cmt_fold !== 12'h001) begin n_err++; $display("FAIL flushcmt_cfold got %h want 001", dut1.cmt_fold); end
   endtask

   task automatic test_reset_mid();
      idle(); req_valid = 1; req_pc = 30'h0000_3005; spec_valid = 1; spec_taken = 1; cycle();
      rst = 1; cycle(); idle();
      n_vec++; if (iv1 !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %0b want 0", iv1); end
      n_vec++; if (idx1 !== 12'h000) begin n_err++; $display("FAIL rstmid_idx got %h want 000", idx1); end
      n_vec++; if (ghr1 !== 32'h0) begin n_err++; $display("FAIL rstmid_ghr got %h want 0", ghr1); end
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      for (int n = 0; n < 10000; n++) begin
         rst        = ($urandom_range(0, 499) == 0);
         req_valid  = $urandom_range(0, 1);
         req_pc     = AW'($urandom);
         spec_valid = ($urandom_range(0, 3) != 0);
         spec_taken = $urandom_range(0, 1);
         cmt_valid  = $urandom_range(0, 1);
         cmt_taken  = $urandom_range(0, 1);
         flush      = ($urandom_range(0, 15) == 0);
         cycle();
         n_vec++;
         if (iv1 !== m_iv || idx1 !== m_idx1 || idx0 !== m_idx0 || ghr1 !== m_spec) begin
            n_err++;
            if (bad < 10) $display("FAIL rand_out cyc %0d got v=%0b i1=%h i0=%h g=%h want v=%0b i1=%h i0=%h g=%h",
                                   n, iv1, idx1, idx0, ghr1, m_iv, m_idx1, m_idx0, m_spec);
            bad++;
         end
         n_vec++;
         if (dut1.spec_fold !== m_fold(m_spec) || dut1.cmt_fold !== m_fold(m_cmt)) begin
            n_err++;
            if (bad < 10) $display("FAIL rand_fold cyc %0d got s=%h c=%h want s=%h c=%h",
                                   n, dut1.spec_fold, dut1.cmt_fold, m_fold(m_spec), m_fold(m_cmt));
            bad++;
         end
      end
      idle();
   endtask

   initial begin
      m_spec = '0; m_cmt = '0; m_idx1 = '0; m_idx0 = '0; m_iv = 0;
      idle();
      test_reset();
      test_pc_fold();
      test_spec_fill();
      test_flush();
      test_flush_commit();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
